sprw_arbiter: RTL and testbench
===============================

Name: sprw_arbiter

Overview:
Shares one SPARROW SIMD pipeline (sprw_wrapper) among NREQ requesters using round-robin arbitration with valid/ready handshakes. Accepted operations are registered into an issue stage that drives the pipeline. A tag shift register travels alongside the pipeline, so each result returns to the requester that issued it. Backpressure on the response side freezes the whole pipeline through sprw_holdn.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 3, requester ID width; must satisfy 2**IDW >= NREQ
SPRW_LAT, 2, clock edges from sprw inputs being presented to sprw_result being valid, counting unstalled edges only

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high
req_ra  in  32*NREQ  operand A; requester i at [32i+31:32i]
req_rb  in  32*NREQ  operand B, same packing as req_ra
req_instr  in  32*NREQ  instruction word, same packing as req_ra
sprw_ra  out  32  to pipeline operand A
sprw_rb  out  32  to pipeline operand B
sprw_instr  out  32  to pipeline instruction
sprw_holdn  out  1  pipeline advance enable (1 = advance)
sprw_result  in  32  pipeline result
rsp_valid  out  NREQ  per-requester response valid; at most one bit high
rsp_data  out  32  response data (shared), equals sprw_result
rsp_ready  in  NREQ  per-requester response accept
busy  out  1  any operation in flight

Behaviour:
- Reset (rst=1, async): issue regs and sprw_ra/rb/instr = 0; all tag valids = 0; RR pointer = 0. Outputs during and after reset: req_ready=0, rsp_valid=0, sprw_holdn=1, busy=0. Operations in flight are discarded; no response is produced for them.
- Tag pipe: stages T[0..SPRW_LAT]; each stage holds {v, id}. T[0] is loaded together with the issue regs. T[j] loads from T[j-1] on every edge where sprw_holdn=1, and holds otherwise.
- Stall: sprw_holdn = !(T[SPRW_LAT].v && !rsp_ready[T[SPRW_LAT].id]). This path is combinational from rsp_ready.
- Response outputs:
  - rsp_valid[i] = T[SPRW_LAT].v && T[SPRW_LAT].id==i.
  - rsp_data = sprw_result.
  - A response completes on the edge where rsp_valid[i] && rsp_ready[i].
- Arbitration is combinational, each cycle:
  - If sprw_holdn=0, all req_ready = 0.
  - Otherwise the winner is the first i with req_valid[i]=1, scanning from ptr and wrapping modulo NREQ. req_ready[winner]=1; all other req_ready = 0.
- Accept edge (req_valid[w] && req_ready[w]):
  - Issue regs load req_ra/rb/instr of w.
  - T[0] loads {1, w}.
  - ptr loads (w+1) mod NREQ.
- Idle edge with holdn=1 and no winner: T[0].v loads 0; issue regs hold their previous data; ptr unchanged.
- Holdn=0 edge: issue regs, T[*] and ptr all hold.
- Latency: an operation accepted at edge k has rsp_valid high in the cycle after edge k+SPRW_LAT, given no stalls. Each stall cycle adds one cycle.
- Throughput: one accept per cycle while unstalled; bubbles are not collapsed.
- req_valid may drop without being accepted; the arbiter keeps no request state.
- Simultaneous events:
  - A response completing and a new accept on the same edge is legal; T shifts normally.
  - A requester may be both responding and requesting in the same cycle.
- ptr always stays in 0..NREQ-1; wrap-around from NREQ-1 to 0.
- busy = OR of T[0..SPRW_LAT].v.

Test Plan:
- Reset: hold rst=1 with req_valid=all ones -> req_ready=0, rsp_valid=0, sprw_holdn=1, busy=0. Release rst -> requester 0 is granted at the first edge.
- Single op: NREQ=2, SPRW_LAT=2; req0 issues ra=0x01020304, rb=0x01010101, accepted at edge 5. Model sprw_result with a 2-deep reference pipeline -> rsp_valid=2'b01 in the cycle after edge 7, rsp_data = model output, busy low after the response completes.
- Round robin: req_valid=2'b11 held for 6 cycles, rsp_ready=all ones -> grant order 0,1,0,1,0,1; responses return in the same order with matching IDs.
- Backpressure: rsp_ready[1]=0 while requester 1's result reaches T[SPRW_LAT], held for 3 cycles -> sprw_holdn=0 and req_ready=0 for 3 cycles, rsp_data stable, issue regs frozen. When rsp_ready[1]=1, the response completes on that edge and the next result follows one cycle later.
- Bubbles: requester 0 valid only on alternate cycles -> T[0].v alternates 1/0; responses are spaced 2 cycles apart; no spurious rsp_valid.
- Reset mid-operation: assert rst with 3 ops in flight -> rsp_valid drops immediately and busy=0. After release, no stale response appears within SPRW_LAT+2 cycles.

Source files
------------

// File: rtl/sprw_arbiter_if.sv
// Requester-side request/response bundle for the SPARROW pipeline arbiter.
// master = requester array, slave = arbiter.
interface sprw_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_ra;
    logic [32*NREQ-1:0] req_rb;
    logic [32*NREQ-1:0] req_instr;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;
    logic [NREQ-1:0]    rsp_ready;

    modport master (
        output req_valid, req_ra, req_rb, req_instr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_ra, req_rb, req_instr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sprw_arbiter.sv
// Round-robin sharing of one SPARROW SIMD pipeline among NREQ requesters.
// A tag pipe tracks each op so its result returns to the issuing requester.
module sprw_arbiter #(
    parameter int NREQ     = 2,
    parameter int IDW      = 3,
    parameter int SPRW_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    sprw_arbiter_if.slave     bus,
    output logic [31:0]       sprw_ra,
    output logic [31:0]       sprw_rb,
    output logic [31:0]       sprw_instr,
    output logic              sprw_holdn,
    input  logic [31:0]       sprw_result,
    output logic              busy
);
    logic [SPRW_LAT:0]          tv;
    logic [SPRW_LAT:0][IDW-1:0] tid;
    logic [IDW-1:0]             ptr;
    logic [IDW-1:0]             nptr;
    logic [IDW-1:0]             win;
    logic                       accept;
    logic [2*NREQ-1:0]          rot;
    logic [IDW:0]               sum;
    logic [31:0]                wra;
    logic [31:0]                wrb;
    logic [31:0]                winstr;

    // Response side: tail tag selects the requester; stall if it is not ready.
    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            bus.rsp_valid[i] = tv[SPRW_LAT] && (tid[SPRW_LAT] == IDW'(i));
    end

    assign sprw_holdn   = ~|(bus.rsp_valid & ~bus.rsp_ready);
    assign bus.rsp_data = sprw_result;
    assign busy         = |tv;

    // Rotate so bit 0 is the requester at ptr, then take the first set bit.
    always_comb begin
        rot    = {bus.req_valid, bus.req_valid} >> ptr;
        accept = 1'b0;
        win    = '0;
        sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!accept && rot[k]) begin
                accept = 1'b1;
                sum    = {1'b0, ptr} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(NREQ))
                    sum = sum - (IDW+1)'(NREQ);
                win = sum[IDW-1:0];
            end
        end
        accept = accept && sprw_holdn && !rst;
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            bus.req_ready[i] = accept && (win == IDW'(i));
    end

    always_comb begin
        wra    = '0;
        wrb    = '0;
        winstr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                wra    = bus.req_ra[32*i +: 32];
                wrb    = bus.req_rb[32*i +: 32];
                winstr = bus.req_instr[32*i +: 32];
            end
        end
    end

    assign nptr = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tv         <= '0;
            tid        <= '0;
            ptr        <= '0;
            sprw_ra    <= '0;
            sprw_rb    <= '0;
            sprw_instr <= '0;
        end else if (sprw_holdn) begin
            tv  <= {tv[SPRW_LAT-1:0], accept};
            tid <= {tid[SPRW_LAT-1:0], win};
            if (accept) begin
                ptr        <= nptr;
                sprw_ra    <= wra;
                sprw_rb    <= wrb;
                sprw_instr <= winstr;
            end
        end
    end
endmodule

// File: tb/tb_sprw_arbiter.sv
// Directed bench for sprw_arbiter with a 2-deep stand-in SPARROW pipeline
// computing (ra + rb) ^ instr.
module tb_sprw_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 3;
    localparam int LAT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sprw_ra;
    logic [31:0] sprw_rb;
    logic [31:0] sprw_instr;
    logic        sprw_holdn;
    logic [31:0] sprw_result;
    logic        busy;
    logic [31:0] p1;
    logic [31:0] p2;
    int          checks = 0;
    int          errors = 0;

    sprw_arbiter_if #(.NREQ(NREQ)) bus ();

    sprw_arbiter #(.NREQ(NREQ), .IDW(IDW), .SPRW_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sprw_ra    (sprw_ra),
        .sprw_rb    (sprw_rb),
        .sprw_instr (sprw_instr),
        .sprw_holdn (sprw_holdn),
        .sprw_result(sprw_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= '0;
            p2 <= '0;
        end else if (sprw_holdn) begin
            p1 <= (sprw_ra + sprw_rb) ^ sprw_instr;
            p2 <= p1;
        end
    end
    assign sprw_result = p2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        bus.req_ra    = '0;
        bus.req_rb    = '0;
        bus.req_instr = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // reset with all requesters asking
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        bus.req_ra    = {32'h0000_0022, 32'h0000_0011};
        bus.req_rb    = '0;
        bus.req_instr = '0;
        step();
        step();
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_holdn", 32'(sprw_holdn), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_grant0", 32'(bus.req_ready), 32'h1);
        step();
        #1;
        chk("rel_issue_ra", sprw_ra, 32'h0000_0011);
        chk("rel_grant1", 32'(bus.req_ready), 32'h2);
        chk("rel_busy", 32'(busy), 32'h1);

        // single op from requester 0
        do_reset();
        bus.req_ra[31:0] = 32'h0102_0304;
        bus.req_rb[31:0] = 32'h0101_0101;
        bus.req_valid    = 2'b01;
        #1;
        chk("single_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        #1;
        chk("single_ra", sprw_ra, 32'h0102_0304);
        chk("single_rv0", 32'(bus.rsp_valid), 32'h0);
        step();
        chk("single_rv1", 32'(bus.rsp_valid), 32'h0);
        step();
        chk("single_rv2", 32'(bus.rsp_valid), 32'h1);
        chk("single_data", bus.rsp_data, 32'h0203_0405);
        step();
        chk("single_done_rv", 32'(bus.rsp_valid), 32'h0);
        chk("single_done_busy", 32'(busy), 32'h0);

        // round robin: op accepted in iteration n answers in iteration n+3
        do_reset();
        bus.req_instr[63:32] = 32'h0000_00F0;
        for (int m = 0; m < 9; m++) begin
            bus.req_valid     = (m < 6) ? 2'b11 : 2'b00;
            bus.req_ra[31:0]  = 32'h1000 + 32'(m);
            bus.req_ra[63:32] = 32'h2000 + 32'(m);
            #1;
            if (m < 6)
                chk("rr_grant", 32'(bus.req_ready), (m % 2 == 0) ? 32'h1 : 32'h2);
            else
                chk("rr_grant_idle", 32'(bus.req_ready), 32'h0);
            if (m >= 3) begin
                chk("rr_rsp_valid", 32'(bus.rsp_valid),
                    ((m - 3) % 2 == 0) ? 32'h1 : 32'h2);
                chk("rr_rsp_data", bus.rsp_data,
                    ((m - 3) % 2 == 0) ? 32'h1000 + 32'(m - 3)
                                       : (32'h2000 + 32'(m - 3)) ^ 32'hF0);
            end else begin
                chk("rr_rsp_quiet", 32'(bus.rsp_valid), 32'h0);
            end
            step();
        end

        // backpressure on requester 1
        do_reset();
        bus.req_ra[63:32] = 32'h0000_000A;
        bus.req_rb[63:32] = 32'h0000_0001;
        bus.req_ra[31:0]  = 32'h0000_0050;
        bus.req_rb[31:0]  = 32'h0000_0005;
        bus.req_valid     = 2'b10;
        #1;
        chk("bp_grant1", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 2'b01;
        #1;
        chk("bp_grant0", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 2'b00;
        step();
        for (int s = 0; s < 3; s++) begin
            bus.rsp_ready = 2'b01;
            bus.req_valid = 2'b11;
            #1;
            chk("bp_holdn", 32'(sprw_holdn), 32'h0);
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h2);
            chk("bp_rsp_data", bus.rsp_data, 32'h0000_000B);
            chk("bp_issue_ra", sprw_ra, 32'h0000_0050);
            step();
        end
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b00;
        #1;
        chk("bp_rel_holdn", 32'(sprw_holdn), 32'h1);
        chk("bp_rel_rv", 32'(bus.rsp_valid), 32'h2);
        step();
        chk("bp_next_rv", 32'(bus.rsp_valid), 32'h1);
        chk("bp_next_data", bus.rsp_data, 32'h0000_0055);
        step();
        chk("bp_end_rv", 32'(bus.rsp_valid), 32'h0);
        chk("bp_end_busy", 32'(busy), 32'h0);

        // bubbles: requester 0 on alternate cycles
        do_reset();
        for (int m = 0; m < 8; m++) begin
            bus.req_valid    = (m % 2 == 0 && m < 6) ? 2'b01 : 2'b00;
            bus.req_ra[31:0] = 32'h300 + 32'(m);
            #1;
            if (m % 2 == 1 && m >= 3) begin
                chk("bub_rv", 32'(bus.rsp_valid), 32'h1);
                chk("bub_data", bus.rsp_data, 32'h300 + 32'(m - 3));
            end else begin
                chk("bub_quiet", 32'(bus.rsp_valid), 32'h0);
            end
            step();
        end

        // reset with three ops in flight
        do_reset();
        bus.req_valid = 2'b11;
        step();
        step();
        step();
        bus.req_valid = 2'b00;
        #1;
        chk("mid_pre_rv", 32'(bus.rsp_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rv", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_holdn", 32'(sprw_holdn), 32'h1);
        step();
        rst = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            #1;
            chk("mid_stale_rv", 32'(bus.rsp_valid), 32'h0);
            step();
        end
        chk("mid_end_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
